// File: rtl/rev_swap_if.sv
// -----------------------------------------------------------------------------
// rev_swap_if
// Bundles the control handshake, the swap-index table port and the shared
// sample-buffer port of rev_swap_ctrl.
//
//   start, busy, done     : pass request / in-progress / completion pulse
//   rom_en, rom_addr      : index-table read (data returns next cycle)
//   rom_dout              : index-table data
//   ram_req, ram_gnt      : buffer arbitration for the 4-cycle swap burst
//   ram_en, ram_we        : buffer enable / write enable
//   ram_addr, ram_wdata   : buffer address / write data
//   ram_rdata             : buffer read data (valid the cycle after a read)
//
// master : the controller side; slave : table, buffer and requester side.
// -----------------------------------------------------------------------------
interface rev_swap_if #(
   parameter int DW = 32
) ();
   logic          start;
   logic          busy;
   logic          done;
   logic          rom_en;
   logic [5:0]    rom_addr;
   logic [8:0]    rom_dout;
   logic          ram_req;
   logic          ram_gnt;
   logic          ram_en;
   logic          ram_we;
   logic [8:0]    ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport master (
      input  start, rom_dout, ram_gnt, ram_rdata,
      output busy, done, rom_en, rom_addr, ram_req, ram_en, ram_we,
             ram_addr, ram_wdata
   );

   modport slave (
      output start, rom_dout, ram_gnt, ram_rdata,
      input  busy, done, rom_en, rom_addr, ram_req, ram_en, ram_we,
             ram_addr, ram_wdata
   );
endinterface

// File: rtl/rev_swap_ctrl.sv
// -----------------------------------------------------------------------------
// rev_swap_ctrl
// Bit-reversal reorder controller. For every entry of a 9-bit swap-index table
// it reads index a, forms b = bit-reverse(a) and, unless a == b, swaps buffer
// words a and b with an uninterruptible 4-cycle burst (RD a, RD b, WR a, WR b)
// once the buffer arbiter grants access.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rev_swap_if.master (control, table port, buffer port)
//
// Outputs are decoded from the current state, so a pass request seen in IDLE
// shows busy on the following cycle, and a reset cancels any write in the
// cycle after it is sampled. Address/data outputs hold their last driven value
// in states that do not use them.
// -----------------------------------------------------------------------------
module rev_swap_ctrl #(
   parameter int DW    = 32,
   parameter int N_ENT = 35
) (
   input  logic        clk,
   input  logic        rst,
   rev_swap_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE, ROM_RD, ROM_LAT, RD_A, RD_B, WR_A, WR_B, DONE
   } state_t;

   state_t        state, state_nx;
   logic [5:0]    idx;
   logic [8:0]    a, b;
   logic          lat_vld;     // a/b already captured during a grant stall
   logic [DW-1:0] data_a;

   logic [8:0]    cur_a, cur_b;
   logic          swap_needed;
   logic          last_ent;
   logic          advance;

   // Last driven values, replayed while the owning output is unused.
   logic [5:0]    rom_addr_q;
   logic [8:0]    ram_addr_q;
   logic [DW-1:0] ram_wdata_q;

   function automatic logic [8:0] bit_rev9(input logic [8:0] v);
      logic [8:0] r;
      for (int i = 0; i < 9; i++) r[i] = v[8-i];
      return r;
   endfunction

   // Table data is only valid in the first ROM_LAT cycle; if the grant stalls,
   // the captured copy is used for the rest of the wait.
   assign cur_a       = lat_vld ? a : bus.rom_dout;
   assign cur_b       = lat_vld ? b : bit_rev9(bus.rom_dout);
   assign swap_needed = (cur_a != cur_b);
   assign last_ent    = (idx == 6'(N_ENT - 1));

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nx      = state;
      advance       = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.rom_en    = 1'b0;
      bus.rom_addr  = rom_addr_q;
      bus.ram_req   = 1'b0;
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = ram_addr_q;
      bus.ram_wdata = ram_wdata_q;

      unique case (state)
         IDLE: begin
            if (bus.start) state_nx = ROM_RD;
         end
         ROM_RD: begin
            bus.busy     = 1'b1;
            bus.rom_en   = 1'b1;
            bus.rom_addr = idx;
            state_nx     = ROM_LAT;
         end
         ROM_LAT: begin
            bus.busy = 1'b1;
            if (!swap_needed) begin
               // Palindromic index: nothing to swap, move to the next entry.
               advance  = 1'b1;
               state_nx = last_ent ? DONE : ROM_RD;
            end else begin
               bus.ram_req = 1'b1;
               if (bus.ram_gnt) state_nx = RD_A;
            end
         end
         RD_A: begin
            bus.busy     = 1'b1;
            bus.ram_req  = 1'b1;
            bus.ram_en   = 1'b1;
            bus.ram_addr = a;
            state_nx     = RD_B;
         end
         RD_B: begin
            bus.busy     = 1'b1;
            bus.ram_req  = 1'b1;
            bus.ram_en   = 1'b1;
            bus.ram_addr = b;
            state_nx     = WR_A;
         end
         WR_A: begin
            // Word read from b arrives now and goes straight back out to a.
            bus.busy      = 1'b1;
            bus.ram_req   = 1'b1;
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = a;
            bus.ram_wdata = bus.ram_rdata;
            state_nx      = WR_B;
         end
         WR_B: begin
            bus.busy      = 1'b1;
            bus.ram_req   = 1'b1;
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = b;
            bus.ram_wdata = data_a;
            advance       = 1'b1;
            state_nx      = last_ent ? DONE : ROM_RD;
         end
         DONE: begin
            bus.done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         a           <= '0;
         b           <= '0;
         lat_vld     <= 1'b0;
         data_a      <= '0;
         rom_addr_q  <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         state       <= state_nx;
         rom_addr_q  <= bus.rom_addr;
         ram_addr_q  <= bus.ram_addr;
         ram_wdata_q <= bus.ram_wdata;

         if (state == IDLE && bus.start)
            idx <= '0;
         else if (advance && !last_ent)
            idx <= idx + 6'd1;

         if (state == ROM_LAT && !lat_vld) begin
            a <= bus.rom_dout;
            b <= bit_rev9(bus.rom_dout);
         end
         lat_vld <= (state == ROM_LAT) && (state_nx == ROM_LAT);

         // Read of a was issued in RD_A, its data is on ram_rdata in RD_B.
         if (state == RD_B) data_a <= bus.ram_rdata;
      end
   end

endmodule
